// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store byte controller: funct3 codes,
// memory width codes, FSM states and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Stores only know SB/SH/SW; loads reject 3, 6 and 7.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        logic ill;
        if (we) begin
            ill = (funct3 > F3_W);
        end else begin
            ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        return ill;
    endfunction

    // The low two funct3 bits double as the access width.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            MEM_HALF: mis = lsb[0];
            MEM_WORD: mis = (lsb != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extender for raw little-endian load data.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext_c
);

    always_comb begin
        ext_c = '0;
        case (funct3)
            F3_B:    ext_c = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext_c = {24'd0, raw[7:0]};
            F3_H:    ext_c = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext_c = {16'd0, raw[15:0]};
            F3_W:    ext_c = raw;
            default: ext_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_ctrl.sv
// Load/store initiator between execute and a byte-addressable data memory:
// one request in flight, one-cycle memory access, held response.
module lsu_byte_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned DPORT       = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DPORT-1:0]  req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DPORT-1:0]  resp_rdata,
    output logic              resp_err,
    output logic              mem_wr,
    output logic [1:0]        mem_byte,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DPORT-1:0]  mem_wdata,
    input  logic [DPORT-1:0]  mem_rdata
);

    state_t             state;
    state_t             state_next;
    logic               we_q;
    logic [2:0]         f3_q;
    logic               req_err_c;
    logic [DPORT-1:0]   ext_c;

    logic               we_d;
    logic [2:0]         f3_d;
    logic               req_ready_d;
    logic               resp_valid_d;
    logic               resp_err_d;
    logic [DPORT-1:0]   resp_rdata_d;
    logic               mem_wr_d;
    logic [1:0]         mem_byte_d;
    logic [AWIDTH-1:0]  mem_addr_d;
    logic [DPORT-1:0]   mem_wdata_d;

    lsu_load_ext u_load_ext (
        .funct3 (f3_q),
        .raw    (mem_rdata),
        .ext_c  (ext_c)
    );

    assign req_err_c = funct3_illegal(req_we, req_funct3)
                     || (ALIGN_CHECK && misaligned(req_funct3, req_addr[1:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_next   = state;
        we_d         = we_q;
        f3_d         = f3_q;
        resp_valid_d = resp_valid;
        resp_err_d   = resp_err;
        resp_rdata_d = resp_rdata;
        mem_wr_d     = 1'b0;
        mem_byte_d   = mem_byte;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d = req_we;
                    f3_d = req_funct3;
                    if (req_err_c) begin
                        // Rejected requests never touch the memory port.
                        state_next   = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_next  = ST_ACCESS;
                        mem_wr_d    = req_we;
                        mem_byte_d  = req_funct3[1:0];
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                state_next   = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? '0 : ext_c;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next   = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_next == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_wr     <= 1'b0;
            mem_byte   <= MEM_WORD;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            we_q       <= we_d;
            f3_q       <= f3_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_wr     <= mem_wr_d;
            mem_byte   <= mem_byte_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_byte_ctrl.sv
// Directed self-checking bench for lsu_byte_ctrl with a byte-array memory model.
module tb_lsu_byte_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr;
    logic [1:0]  mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_count    = 0;

    logic [7:0]  mem [0:4095];
    logic        poke_en;
    logic [11:0] poke_addr;
    logic [7:0]  poke_data;
    logic        watch;
    logic        stray;

    lsu_byte_ctrl #(.AWIDTH(32), .DPORT(32), .ALIGN_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wr     (mem_wr),
        .mem_byte   (mem_byte),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte-lane write, plus a bench-side poke port for preloading.
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_wr) begin
            mem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_byte != 2'd0) mem[12'(mem_addr[11:0] + 12'd1)] <= mem_wdata[15:8];
            if (mem_byte == 2'd2) begin
                mem[12'(mem_addr[11:0] + 12'd2)] <= mem_wdata[23:16];
                mem[12'(mem_addr[11:0] + 12'd3)] <= mem_wdata[31:24];
            end
            wr_count <= wr_count + 1;
        end
    end

    assign mem_rdata = {mem[12'(mem_addr[11:0] + 12'd3)], mem[12'(mem_addr[11:0] + 12'd2)],
                        mem[12'(mem_addr[11:0] + 12'd1)], mem[mem_addr[11:0]]};

    always @(posedge clk) begin
        if (!watch) stray <= 1'b0;
        else if (resp_valid) stray <= 1'b1;
    end

    function automatic logic [31:0] peek32(input logic [11:0] a);
        return {mem[12'(a + 12'd3)], mem[12'(a + 12'd2)], mem[12'(a + 12'd1)], mem[a]};
    endfunction

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Issue one request and sample right after acceptance (v1/w1/b1) and, for
    // non-error paths, one edge later (v2/w2). Response data taken at the last sample.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic ok, output int acc_cyc,
                        output logic v1, output logic w1, output logic [1:0] b1,
                        output logic v2, output logic w2, output logic [31:0] rdata,
                        output logic err);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        req_valid = 1'b0;
        req_addr  = 'x;
        req_wdata = 'x;
        acc_cyc = cyc;
        v1    = resp_valid;
        w1    = mem_wr;
        b1    = mem_byte;
        rdata = resp_rdata;
        err   = resp_err;
        v2    = v1;
        w2    = w1;
        if (ok && !v1) begin
            @(posedge clk);
            #1;
            v2    = resp_valid;
            w2    = mem_wr;
            rdata = resp_rdata;
            err   = resp_err;
        end
    endtask

    task automatic test_reset();
        logic [7:0] pre [0:11];
        pre = '{8'h80, 8'h7F, 8'h01, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                8'h00, 8'h00, 8'h00, 8'h00};
        rst = 1'b1;
        for (int i = 0; i < 12; i++) poke(12'(12'h100 + i), pre[i]);
        @(posedge clk);
        #1;
        vectors++;
        if ({req_ready, resp_valid, resp_err, mem_wr, mem_byte} !== 6'b1_0_0_0_10) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100010",
                     {req_ready, resp_valid, resp_err, mem_wr, mem_byte});
        end
        vectors++;
        if (resp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 00000000", resp_rdata);
        end
        vectors++;
        if (mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want 00000000", mem_addr);
        end
        vectors++;
        if (mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wdata: got %h want 00000000", mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [0:5];
        logic [31:0] adrs [0:5];
        logic [31:0] exps [0:5];
        logic ok, v1, w1, v2, w2, err;
        logic [1:0] b1;
        logic [31:0] rd;
        int ac;
        f3s  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd2};
        adrs = '{32'h100, 32'h100, 32'h100, 32'h102, 32'h102, 32'h100};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80, 32'h0000FF01,
                 32'hFFFFFF01, 32'hFF017F80};
        for (int i = 0; i < 6; i++) begin
            xact(1'b0, f3s[i], adrs[i], 32'h0, ok, ac, v1, w1, b1, v2, w2, rd, err);
            vectors++;
            if ({ok, v1, w1, v2, w2} !== 5'b1_0_0_1_0) begin
                miscompares++;
                $display("FAIL load%0d_timing: got %b want 10010", i, {ok, v1, w1, v2, w2});
            end
            vectors++;
            if ({err, rd} !== {1'b0, exps[i]}) begin
                miscompares++;
                $display("FAIL load%0d_data: got err=%b %h want err=0 %h", i, err, rd, exps[i]);
            end
        end
    endtask

    task automatic test_store_byte();
        logic ok, v1, w1, v2, w2, err;
        logic [1:0] b1;
        logic [31:0] rd;
        int ac, c0;
        c0 = wr_count;
        xact(1'b1, 3'd0, 32'h104, 32'h123456EF, ok, ac, v1, w1, b1, v2, w2, rd, err);
        vectors++;
        if ({ok, v1, w1, b1} !== 5'b1_0_1_00) begin
            miscompares++;
            $display("FAIL sb_access: got %b want 10100", {ok, v1, w1, b1});
        end
        vectors++;
        if ({v2, w2, err, rd} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL sb_resp: got %b %h want 100 00000000", {v2, w2, err}, rd);
        end
        vectors++;
        if ({mem_addr, mem_wdata} !== {32'h104, 32'h123456EF}) begin
            miscompares++;
            $display("FAIL sb_port: got %h %h want 00000104 123456ef", mem_addr, mem_wdata);
        end
        vectors++;
        if (wr_count - c0 !== 1) begin
            miscompares++;
            $display("FAIL sb_wr_count: got %0d want 1", wr_count - c0);
        end
        xact(1'b0, 3'd2, 32'h104, 32'h0, ok, ac, v1, w1, b1, v2, w2, rd, err);
        vectors++;
        if ({ok, err, rd} !== {2'b10, 32'hDDCCBBEF}) begin
            miscompares++;
            $display("FAIL sb_readback: got %b %h want 10 ddccbbef", {ok, err}, rd);
        end
    endtask

    task automatic test_errors();
        logic        wes  [0:3];
        logic [2:0]  f3s  [0:3];
        logic [31:0] adrs [0:3];
        logic ok, v1, w1, v2, w2, err;
        logic [1:0] b1;
        logic [31:0] rd, m0, m1;
        int ac, c0;
        wes  = '{1'b0, 1'b1, 1'b0, 1'b1};
        f3s  = '{3'd2, 3'd1, 3'd3, 3'd4};
        adrs = '{32'h101, 32'h103, 32'h100, 32'h100};
        c0 = wr_count;
        m0 = peek32(12'h100);
        m1 = peek32(12'h104);
        for (int i = 0; i < 4; i++) begin
            xact(wes[i], f3s[i], adrs[i], 32'hAAAA5555, ok, ac, v1, w1, b1, v2, w2, rd, err);
            vectors++;
            if ({ok, v1, w1, err} !== 4'b1_1_0_1) begin
                miscompares++;
                $display("FAIL err%0d_flags: got %b want 1101", i, {ok, v1, w1, err});
            end
            vectors++;
            if (rd !== 32'h0) begin
                miscompares++;
                $display("FAIL err%0d_rdata: got %h want 00000000", i, rd);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (wr_count - c0 !== 0) begin
            miscompares++;
            $display("FAIL err_no_write: got %0d writes want 0", wr_count - c0);
        end
        vectors++;
        if ({peek32(12'h100), peek32(12'h104)} !== {32'hFF017F80, 32'hDDCCBBEF}
            || m0 !== 32'hFF017F80 || m1 !== 32'hDDCCBBEF) begin
            miscompares++;
            $display("FAIL err_mem_intact: got %h %h want ff017f80 ddccbbef",
                     peek32(12'h100), peek32(12'h104));
        end
    endtask

    task automatic test_backpressure();
        logic ok, v1, w1, v2, w2, err;
        logic [1:0] b1;
        logic [31:0] rd;
        int ac;
        resp_ready = 1'b0;
        xact(1'b0, 3'd2, 32'h100, 32'h0, ok, ac, v1, w1, b1, v2, w2, rd, err);
        vectors++;
        if ({ok, v2, err, rd} !== {3'b110, 32'hFF017F80}) begin
            miscompares++;
            $display("FAIL bp_first: got %b %h want 110 ff017f80", {ok, v2, err}, rd);
        end
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h10C;
        req_wdata  = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({resp_valid, resp_err, resp_rdata, req_ready, mem_wr}
                !== {2'b10, 32'hFF017F80, 2'b00}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b e=%b %h rdy=%b wr=%b", i,
                         resp_valid, resp_err, resp_rdata, req_ready, mem_wr);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({resp_valid, req_ready, mem_wr} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_release: got %b want 010", {resp_valid, req_ready, mem_wr});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h10C, 32'h55AA55AA}) begin
            miscompares++;
            $display("FAIL bp_next_accept: got %b %h %h want 1 0000010c 55aa55aa",
                     mem_wr, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({resp_valid, resp_err, mem_wr} !== 3'b100) begin
            miscompares++;
            $display("FAIL bp_next_resp: got %b want 100", {resp_valid, resp_err, mem_wr});
        end
    endtask

    task automatic test_reset_midop();
        logic ok;
        int c0;
        c0 = wr_count;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h108;
        req_wdata  = 32'hCAFEF00D;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        req_valid = 1'b0;
        vectors++;
        if ({ok, mem_wr} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_access_entry: got %b want 11", {ok, mem_wr});
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({mem_wr, resp_valid, req_ready, resp_err} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rst_async: got %b want 0010", {mem_wr, resp_valid, req_ready, resp_err});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst   = 1'b0;
        watch = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if ({stray, resp_valid, req_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_no_resp: got %b want 001", {stray, resp_valid, req_ready});
        end
        vectors++;
        if ({wr_count - c0, peek32(12'h108)} !== {32'd0, 32'h0}) begin
            miscompares++;
            $display("FAIL rst_store_abandoned: got %0d writes mem %h want 0 00000000",
                     wr_count - c0, peek32(12'h108));
        end
        watch = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic ok, v1, w1, v2, w2, err;
        logic [1:0] b1;
        logic [31:0] rd, d;
        int ac, first, last, c0;
        resp_ready = 1'b1;
        c0 = wr_count;
        first = 0;
        last  = 0;
        for (int i = 0; i < 8; i++) begin
            d = {8'(i), 8'hC3, ~8'(i), 8'h5A};
            xact(1'b1, 3'd2, 32'h200 + 32'(4 * i), d, ok, ac, v1, w1, b1, v2, w2, rd, err);
            if (i == 0) first = ac;
            vectors++;
            if ({ok, v1, w1, b1, v2, w2, err} !== 8'b1_0_1_10_1_0_0) begin
                miscompares++;
                $display("FAIL b2b_sw%0d: got %b want 10110100", i, {ok, v1, w1, b1, v2, w2, err});
            end
            xact(1'b0, 3'd2, 32'h200 + 32'(4 * i), 32'h0, ok, ac, v1, w1, b1, v2, w2, rd, err);
            last = ac;
            vectors++;
            if ({ok, err, rd} !== {2'b10, d}) begin
                miscompares++;
                $display("FAIL b2b_lw%0d: got %b %h want 10 %h", i, {ok, err}, rd, d);
            end
        end
        vectors++;
        if (last - first !== 45) begin
            miscompares++;
            $display("FAIL b2b_rate: got %0d cycles want 45", last - first);
        end
        vectors++;
        if (wr_count - c0 !== 8) begin
            miscompares++;
            $display("FAIL b2b_wr_count: got %0d want 8", wr_count - c0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        poke_en    = 1'b0;
        poke_addr  = 12'h0;
        poke_data  = 8'h0;
        watch      = 1'b0;
        test_reset();
        test_loads();
        test_store_byte();
        test_errors();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
